acc_bank: RTL and testbench
===========================

Name: acc_bank

Overview:
- Parametrised successor to the processor's single accumulator register.
- Holds NUM_ACC accumulators of WIDTH bits behind a valid/ready operation port.
- Supports load, arithmetic, logic and multi-cycle serial-shift ops, with status flags and optional saturation.
- Sits between the datapath bus and the ALU/control sequencer.
- Read data is registered and held; the block never drives high-impedance.

Parameters:
- WIDTH, 18, accumulator and data width in bits.
- NUM_ACC, 4, number of accumulators; power of two, at least 1.
- SAT, 0, 1 = ADD/SUB clamp to signed max/min on overflow; 0 = wrap.
- SELW = max(1, clog2(NUM_ACC)); SHW = clog2(WIDTH)+1. Both are derived, not overridable.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- op_valid  in  1  operation request.
- op_ready  out  1  block can accept an op; high only in IDLE.
- op  in  4  opcode (see Behaviour).
- sel  in  SELW  target accumulator index.
- din  in  WIDTH  operand; for shift ops, din[SHW-1:0] is the shift amount.
- dout  out  WIDTH  registered read data; holds its last value.
- dout_valid  out  1  one-cycle pulse, cycle after a READ is accepted.
- err  out  1  one-cycle pulse, cycle after an op with sel >= NUM_ACC is accepted.
- flag_z, flag_n, flag_c, flag_v  out  1 each  status of the last flag-updating op.

Behaviour:
- Reset (async): all accumulators, dout, dout_valid, err and flags go to 0; FSM goes to IDLE; op_ready goes to 1 on the first clk edge after reset deasserts. Reset mid-shift aborts the shift.
- Accept: an op is accepted on a rising edge when op_valid && op_ready. When op_ready=0, the requester holds op, sel and din stable.
- Opcodes (A = acc[sel]):
  - 0 NOP.
  - 1 LOAD: A = din.
  - 2 ADD: A = A + din.
  - 3 SUB: A = A - din.
  - 4 AND, 5 OR, 6 XOR: A = A op din.
  - 7 CLR: A = 0.
  - 8 SHL: logical shift left.
  - 9 SHR: logical shift right.
  - 10 SRA: arithmetic shift right.
  - 11 READ: dout = A.
  - 12-15: treated as NOP.
- Single-cycle ops (1-7, 11) update state on the accept edge.
- READ: dout is loaded at the accept edge and dout_valid is 1 for exactly that following cycle. dout is unchanged by all other ops.
- Flags: updated by ops 1-10 only. They reflect the value written to A.
  - Z = result==0.
  - N = result MSB.
  - C: ADD = carry out; SUB = borrow (unsigned A < din); shifts = last bit shifted out; otherwise 0.
  - V: ADD/SUB = signed overflow; otherwise 0.
- SAT=1: on ADD/SUB signed overflow, A clamps to 2^(WIDTH-1)-1 if the true result is positive, else -2^(WIDTH-1). V is still set to 1. C is still computed from the unclamped operation.
- Shift FSM, states IDLE and SHIFT. Shift amount n = din[SHW-1:0], clamped to WIDTH.
  - n=0: A unchanged; flags updated, C=0; stay in IDLE; op_ready stays 1.
  - n>=1: first 1-bit shift at the accept edge; counter = n-1.
  - If counter > 0, go to SHIFT, with one 1-bit shift per cycle while decrementing.
  - Return to IDLE on the edge where the counter reaches 0.
  - op_ready is 0 for exactly n-1 cycles.
  - Flags are updated once, at the final shift edge.
  - Shift target sel is latched at accept.
- Fill bits: SHL fills with 0; SHR fills with 0; SRA replicates the MSB.
- Invalid sel (sel >= NUM_ACC, only possible in non-power-of-two builds): the op is consumed, there is no state or flag change, and err pulses for 1 cycle.
- Accumulators other than the one selected are never modified.

Test Plan:
- Reset then READ sel=2 -> dout=0, dout_valid high for 1 cycle, all flags 0; assert rst mid-operation -> outputs clear immediately, without a clock edge.
- LOAD sel=1 din=0x1FFFF, then ADD din=1, SAT=0 -> acc1=0x20000, N=1, V=1, C=0; repeat with SAT=1 -> acc1=0x1FFFF, V=1.
- LOAD sel=0 din=5, SUB din=7 -> acc0=0x3FFFE, C=1 (borrow), N=1, V=0; SUB din=0x3FFFE -> Z=1.
- LOAD sel=3 din=0x20001, SRA din=4 -> op_ready low exactly 3 cycles, acc3=0x3E000, C=0; SHL din=0 -> unchanged, ready never drops, C=0.
- SHR sel=0 of 0x00003 by 31 (clamped to 18) -> acc0=0, C=0 (the last bit out is the MSB, which is 0), 17 busy cycles; op_valid held throughout is accepted only after op_ready rises.
- Write distinct values to all four accumulators, XOR acc2 with 0x3FFFF, READ each -> only acc2 inverted; READ back-to-back gives dout_valid high on consecutive cycles.

Source files
------------

// File: rtl/acc_bank.sv
// acc_bank: bank of NUM_ACC accumulators with ALU ops, serial shifter, read port and status flags
module acc_bank #(
    parameter int WIDTH   = 18,
    parameter int NUM_ACC = 4,
    parameter bit SAT     = 1'b0,
    localparam int SELW   = NUM_ACC > 1 ? $clog2(NUM_ACC) : 1,
    localparam int SHW    = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op,
    input  logic [SELW-1:0]  sel,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    output logic             err,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
);
    localparam logic [3:0] OP_LOAD = 4'd1, OP_ADD = 4'd2, OP_SUB = 4'd3, OP_AND = 4'd4,
                           OP_OR = 4'd5, OP_XOR = 4'd6, OP_CLR = 4'd7, OP_SHL = 4'd8,
                           OP_SHR = 4'd9, OP_SRA = 4'd10, OP_READ = 4'd11;
    localparam logic [SELW:0]  NACC = (SELW + 1)'(NUM_ACC);
    localparam logic [SHW-1:0] WMAX = SHW'(WIDTH);
    localparam logic [SHW-1:0] ONE  = SHW'(1);
    localparam int M = WIDTH - 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t           state;
    logic [WIDTH-1:0] acc [NUM_ACC];
    logic [SELW-1:0]  tsel, cur_sel;
    logic [3:0]       top, cur_op;
    logic [SHW-1:0]   cnt, n;
    logic [WIDTH:0]   sum, dif;
    logic [WIDTH-1:0] a, res;
    logic             accept, sel_ok, is_shift, upd, long_shift, c, v;

    // During a serial shift the latched target and opcode drive the datapath
    assign accept     = op_valid && op_ready;
    assign cur_sel    = state == SHIFT ? tsel : sel;
    assign cur_op     = state == SHIFT ? top : op;
    assign sel_ok     = {1'b0, cur_sel} < NACC;
    assign a          = sel_ok ? acc[cur_sel] : '0;
    assign n          = din[SHW-1:0] > WMAX ? WMAX : din[SHW-1:0];
    assign is_shift   = cur_op inside {OP_SHL, OP_SHR, OP_SRA};
    assign upd        = cur_op >= OP_LOAD && cur_op <= OP_SRA;
    assign long_shift = is_shift && n > ONE;
    assign sum        = {1'b0, a} + {1'b0, din};
    assign dif        = {1'b0, a} - {1'b0, din};

    // ALU: result, carry/borrow/shift-out and overflow for the op in flight
    always_comb begin
        res = a;
        c   = 1'b0;
        v   = 1'b0;
        case (cur_op)
            OP_LOAD: res = din;
            OP_ADD: begin
                res = sum[M:0];
                c   = sum[WIDTH];
                v   = a[M] == din[M] && sum[M] != a[M];
            end
            OP_SUB: begin
                res = dif[M:0];
                c   = dif[WIDTH];
                v   = a[M] != din[M] && dif[M] != a[M];
            end
            OP_AND: res = a & din;
            OP_OR:  res = a | din;
            OP_XOR: res = a ^ din;
            OP_CLR: res = '0;
            OP_SHL: {c, res} = {a, 1'b0};
            OP_SHR: {res, c} = {1'b0, a};
            OP_SRA: {res, c} = {a[M], a};
            default: ;
        endcase
        if (SAT && v) res = a[M] ? {1'b1, {M{1'b0}}} : {1'b0, {M{1'b1}}};
        if (is_shift && state == IDLE && n == '0) begin
            res = a;
            c   = 1'b0;
        end
    end

    // Sequencer: accepts ops, writes the target, runs the serial shift, registers read data and flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            op_ready   <= 1'b0;
            acc        <= '{default: '0};
            tsel       <= '0;
            top        <= '0;
            cnt        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            err        <= 1'b0;
            {flag_z, flag_n, flag_c, flag_v} <= '0;
        end else begin
            dout_valid <= 1'b0;
            err        <= 1'b0;
            if (state == IDLE) begin
                op_ready <= !(accept && sel_ok && long_shift);
                if (accept && !sel_ok) err <= 1'b1;
                if (accept && sel_ok) begin
                    if (upd) acc[sel] <= res;
                    if (upd && !long_shift) {flag_z, flag_n, flag_c, flag_v} <= {res == '0, res[M], c, v};
                    if (op == OP_READ) begin
                        dout       <= a;
                        dout_valid <= 1'b1;
                    end
                    if (long_shift) begin
                        state <= SHIFT;
                        tsel  <= sel;
                        top   <= op;
                        cnt   <= n - ONE;
                    end
                end
            end else begin
                acc[tsel] <= res;
                cnt       <= cnt - ONE;
                if (cnt == ONE) begin
                    state    <= IDLE;
                    op_ready <= 1'b1;
                    {flag_z, flag_n, flag_c, flag_v} <= {res == '0, res[M], c, v};
                end
            end
        end
    end
endmodule

// File: tb/tb_acc_bank.sv
// tb_acc_bank: table vectors, corner sequences and randomized model check of acc_bank (SAT=0 and SAT=1)
module tb_acc_bank;
    localparam int     W    = 18;
    localparam longint MASK = (longint'(1) << W) - 1;
    localparam longint MAXP = (longint'(1) << (W - 1)) - 1;
    localparam longint MINN = -(longint'(1) << (W - 1));

    logic clk = 1'b0, rst = 1'b1, op_valid = 1'b0;
    logic [3:0]   op  = '0;
    logic [1:0]   sel = '0;
    logic [W-1:0] din = '0;
    logic [1:0]   op_ready, dout_valid, err, fz, fn, fc, fv;
    logic [1:0][W-1:0] dout;

    int total = 0, bad = 0;

    longint     m_acc [2][4];
    logic [3:0] m_f   [2];
    longint     m_dout[2];

    acc_bank #(.WIDTH(W), .NUM_ACC(4), .SAT(1'b0)) u0 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready[0]), .op(op), .sel(sel),
        .din(din), .dout(dout[0]), .dout_valid(dout_valid[0]), .err(err[0]),
        .flag_z(fz[0]), .flag_n(fn[0]), .flag_c(fc[0]), .flag_v(fv[0]));

    acc_bank #(.WIDTH(W), .NUM_ACC(4), .SAT(1'b1)) u1 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready[1]), .op(op), .sel(sel),
        .din(din), .dout(dout[1]), .dout_valid(dout_valid[1]), .err(err[1]),
        .flag_z(fz[1]), .flag_n(fn[1]), .flag_c(fc[1]), .flag_v(fv[1]));

    initial forever #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [3:0] o;
        int         s;
        longint     d;
        logic [3:0] f;
        int         busy;
        bit         rd;
        longint     d0;
        longint     d1;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic longint sx(input longint x);
        return x[W-1] ? x - (longint'(1) << W) : x;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) m_acc[k][j] = 0;
            m_f[k]    = '0;
            m_dout[k] = 0;
        end
    endtask

    task automatic model(input logic [3:0] o, input int s, input longint d, output int busy);
        int     n;
        longint a, r, st;
        bit     c, v;
        n = int'(d & 63);
        if (n > W) n = W;
        for (int k = 0; k < 2; k++) begin
            a  = m_acc[k][s];
            r  = a;
            st = 0;
            c  = 1'b0;
            v  = 1'b0;
            case (o)
                4'd1: r = d;
                4'd2: begin
                    st = sx(a) + sx(d);
                    r  = (a + d) & MASK;
                    c  = ((a + d) >> W) != 0;
                    v  = st > MAXP || st < MINN;
                end
                4'd3: begin
                    st = sx(a) - sx(d);
                    r  = (a - d) & MASK;
                    c  = a < d;
                    v  = st > MAXP || st < MINN;
                end
                4'd4: r = a & d;
                4'd5: r = a | d;
                4'd6: r = a ^ d;
                4'd7: r = 0;
                4'd8: if (n > 0) begin r = (a << n) & MASK; c = ((a >> (W - n)) & 1) != 0; end
                4'd9: if (n > 0) begin r = a >> n; c = ((a >> (n - 1)) & 1) != 0; end
                4'd10: if (n > 0) begin r = (sx(a) >>> n) & MASK; c = ((a >> (n - 1)) & 1) != 0; end
                4'd11: m_dout[k] = a;
                default: ;
            endcase
            if (k == 1 && v) r = st > 0 ? MAXP : (MINN & MASK);
            if (o >= 4'd1 && o <= 4'd10) begin
                m_acc[k][s] = r;
                m_f[k]      = {r == 0, r[W-1], c, v};
            end
        end
        busy = (o >= 4'd8 && o <= 4'd10 && n > 0) ? n - 1 : 0;
    endtask

    task automatic do_op(input logic [3:0] o, input int s, input longint d, output int busy);
        int eb;
        model(o, s, d, eb);
        op       = o;
        sel      = s[1:0];
        din      = d[W-1:0];
        op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        for (int k = 0; k < 2; k++)
            chk($sformatf("dout_valid%0d op%0d", k, o), longint'(dout_valid[k]), longint'(o == 4'd11));
        busy = 0;
        while (op_ready[0] !== 1'b1 && busy < 100) begin
            @(posedge clk);
            #1;
            busy++;
        end
        chk($sformatf("busy op%0d", o), busy, eb);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("ready%0d", k), longint'(op_ready[k]), 1);
            chk($sformatf("flags%0d op%0d", k, o), longint'({fz[k], fn[k], fc[k], fv[k]}), longint'(m_f[k]));
            chk($sformatf("dout%0d", k), longint'(dout[k]), m_dout[k]);
            chk($sformatf("err%0d", k), longint'(err[k]), 0);
        end
    endtask

    initial begin
        int busy, cyc;
        logic [3:0] ro;
        longint rd;
        model_reset();

        // reset state
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_ready%0d", k), longint'(op_ready[k]), 0);
            chk($sformatf("rst_flags%0d", k), longint'({fz[k], fn[k], fc[k], fv[k]}), 0);
            chk($sformatf("rst_dout%0d", k), longint'(dout[k]), 0);
            chk($sformatf("rst_dv%0d", k), longint'(dout_valid[k]), 0);
        end
        rst = 1'b0;
        #1;
        chk("ready_before_edge", longint'(op_ready[0]), 0);
        @(posedge clk);
        #1;
        chk("ready_after_edge", longint'(op_ready[0]), 1);

        tbl.push_back('{4'd11, 2, 0,        4'b0000, 0,  1, 0,        0});
        tbl.push_back('{4'd1,  1, 'h1FFFF,  4'b0000, 0,  0, 0,        0});
        tbl.push_back('{4'd2,  1, 1,        4'b0101, 0,  0, 0,        0});
        tbl.push_back('{4'd11, 1, 0,        4'b0101, 0,  1, 'h20000,  'h1FFFF});
        tbl.push_back('{4'd1,  0, 5,        4'b0000, 0,  0, 0,        0});
        tbl.push_back('{4'd3,  0, 7,        4'b0110, 0,  0, 0,        0});
        tbl.push_back('{4'd11, 0, 0,        4'b0110, 0,  1, 'h3FFFE,  'h3FFFE});
        tbl.push_back('{4'd3,  0, 'h3FFFE,  4'b1000, 0,  0, 0,        0});
        tbl.push_back('{4'd1,  3, 'h20001,  4'b0100, 0,  0, 0,        0});
        tbl.push_back('{4'd10, 3, 4,        4'b0100, 3,  0, 0,        0});
        tbl.push_back('{4'd11, 3, 0,        4'b0100, 0,  1, 'h3E000,  'h3E000});
        tbl.push_back('{4'd8,  3, 0,        4'b0100, 0,  0, 0,        0});
        tbl.push_back('{4'd1,  0, 3,        4'b0000, 0,  0, 0,        0});
        tbl.push_back('{4'd9,  0, 31,       4'b1000, 17, 0, 0,        0});
        tbl.push_back('{4'd1,  0, 'h11111,  4'b0000, 0,  0, 0,        0});
        tbl.push_back('{4'd1,  1, 'h02222,  4'b0000, 0,  0, 0,        0});
        tbl.push_back('{4'd1,  2, 'h13333,  4'b0000, 0,  0, 0,        0});
        tbl.push_back('{4'd1,  3, 'h04444,  4'b0000, 0,  0, 0,        0});
        tbl.push_back('{4'd6,  2, 'h3FFFF,  4'b0100, 0,  0, 0,        0});
        tbl.push_back('{4'd11, 0, 0,        4'b0100, 0,  1, 'h11111,  'h11111});
        tbl.push_back('{4'd11, 1, 0,        4'b0100, 0,  1, 'h02222,  'h02222});
        tbl.push_back('{4'd11, 2, 0,        4'b0100, 0,  1, 'h2CCCC,  'h2CCCC});
        tbl.push_back('{4'd11, 3, 0,        4'b0100, 0,  1, 'h04444,  'h04444});

        foreach (tbl[i]) begin
            do_op(tbl[i].o, tbl[i].s, tbl[i].d, busy);
            chk($sformatf("tbl%0d_flags", i), longint'({fz[0], fn[0], fc[0], fv[0]}), longint'(tbl[i].f));
            chk($sformatf("tbl%0d_busy", i), busy, tbl[i].busy);
            if (tbl[i].rd) begin
                chk($sformatf("tbl%0d_dout0", i), longint'(dout[0]), tbl[i].d0);
                chk($sformatf("tbl%0d_dout1", i), longint'(dout[1]), tbl[i].d1);
            end
        end

        // op_valid held through a long shift: the READ is taken only once ready returns
        do_op(4'd1, 0, 3, busy);
        model(4'd9, 0, 31, busy);
        model(4'd11, 0, 0, busy);
        op = 4'd9; sel = 2'd0; din = 18'd31; op_valid = 1'b1;
        @(posedge clk);
        #1;
        op = 4'd11; din = '0;
        cyc = 0;
        do begin
            @(posedge clk);
            #1;
            cyc++;
        end while (dout_valid[0] !== 1'b1 && cyc < 100);
        op_valid = 1'b0;
        chk("held_read_latency", cyc, 18);
        chk("held_read_dout", longint'(dout[0]), 0);
        chk("held_read_flags", longint'({fz[0], fn[0], fc[0], fv[0]}), 4'b1000);

        // reset in the middle of a shift clears outputs without a clock edge
        do_op(4'd1, 1, 'h3FFFF, busy);
        do_op(4'd11, 1, 0, busy);
        op = 4'd8; sel = 2'd1; din = 18'd10; op_valid = 1'b1;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("midrst_ready%0d", k), longint'(op_ready[k]), 0);
            chk($sformatf("midrst_dout%0d", k), longint'(dout[k]), 0);
            chk($sformatf("midrst_flags%0d", k), longint'({fz[k], fn[k], fc[k], fv[k]}), 0);
        end
        #2;
        rst = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        chk("midrst_ready_back", longint'(op_ready[0]), 1);
        do_op(4'd11, 1, 0, busy);
        chk("midrst_acc1_cleared", longint'(dout[0]), 0);

        // randomized ops against the reference model
        for (int i = 0; i < 300; i++) begin
            ro = 4'($urandom_range(0, 15));
            rd = longint'($urandom) & MASK;
            if (ro >= 4'd8 && ro <= 4'd10 && $urandom_range(0, 1) == 1) rd = longint'($urandom_range(0, 20));
            do_op(ro, int'($urandom_range(0, 3)), rd, busy);
        end
        for (int j = 0; j < 4; j++) do_op(4'd11, j, 0, busy);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
